// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the oversampled SPI slave.
//   state_t          : frame state (IDLE, ACTIVE)
//   SYNC_*           : bit positions of sck/cs/si inside the synchroniser vector
//   sample_is_rise() : derives which SCK transition samples SI from CPOL/CPHA
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int SYNC_W   = 3;
  localparam int SYNC_SCK = 2;
  localparam int SYNC_CS  = 1;
  localparam int SYNC_SI  = 0;

  // The lead edge is the rise when CPOL=0. CPHA=0 samples on the lead edge and
  // CPHA=1 on the trailing edge, so sampling happens on the rise exactly when
  // CPOL and CPHA agree. The shift edge is always the opposite transition.
  function automatic logic sample_is_rise(input logic cpol, input logic cpha);
    return cpol ~^ cpha;
  endfunction

endpackage

// File: rtl/spi_slave_sync_sync2.sv
// sync2
// Two-flop synchroniser for asynchronous level inputs, WIDTH bits wide.
//   clock   : destination clock
//   reset_n : synchronous active-low reset, clears both stages to 0
//   d       : asynchronous inputs
//   q       : synchronised outputs, two clock cycles behind d
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // Clearing to 0 means a CS that is already low when reset releases never
  // produces a falling edge, so a frame in progress at that moment is ignored.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync
// SPI slave clocked entirely by the system clock. SCK, CS and SI are
// synchronised and edge-detected; all four CPOL/CPHA modes, either bit order
// and back-to-back words inside one chip-select frame are supported.
//   clock, reset_n      : system clock, synchronous active-low reset
//   sck, cs, si         : SPI pins from the master (asynchronous, cs active low)
//   so, so_oe           : MISO data and its output enable
//   rx_data, rx_valid   : last received word and its one-cycle strobe
//   tx_data, tx_valid   : next word to send and its availability
//   tx_ready            : strobe, tx_data is consumed this cycle
//   tx_underrun         : strobe, FILL is loaded because no tx word was valid
//   frame_active        : high while the slave is inside a CS frame
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter bit               CPOL      = 1'b0,
  parameter bit               CPHA      = 1'b0,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] FILL      = '1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sck,
  input  logic             cs,
  input  logic             si,
  output logic             so,
  output logic             so_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_active
);

  localparam int   CNT_W       = $clog2(WIDTH);
  localparam logic SAMPLE_RISE = sample_is_rise(CPOL, CPHA);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [SYNC_W-1:0] sync_q;
  logic              sck_s;
  logic              cs_s;
  logic              si_s;
  logic              sck_prev_q;
  logic              cs_prev_q;

  logic              sck_rise;
  logic              sck_fall;
  logic              cs_rise;
  logic              cs_fall;
  logic              sample_edge;
  logic              shift_edge;

  state_t            state_q;
  state_t            state_d;

  logic [WIDTH-1:0]  shift_tx_q;
  logic [WIDTH-1:0]  shift_rx_q;
  logic [WIDTH-1:0]  rx_next;
  logic [CNT_W-1:0]  bitcnt_q;
  logic              load_pend_q;
  logic              reload_pend_q;
  logic              skip_shift_q;
  logic              word_done_q;
  logic              rx_valid_q;
  logic [WIDTH-1:0]  rx_data_q;

  logic              enter;
  logic              do_clear;
  logic              do_load;
  logic              do_shift;
  logic              do_skip;
  logic              do_sample;

  sync2 #(
    .WIDTH (SYNC_W)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       ({sck, cs, si}),
    .q       (sync_q)
  );

  assign sck_s = sync_q[SYNC_SCK];
  assign cs_s  = sync_q[SYNC_CS];
  assign si_s  = sync_q[SYNC_SI];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
    end else begin
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
    end
  end

  assign sck_rise    =  sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s &  sck_prev_q;
  assign cs_rise     =  cs_s  & ~cs_prev_q;
  assign cs_fall     = ~cs_s  &  cs_prev_q;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A CS rise takes priority over any SCK edge seen in the same cycle. The
  // entry load runs one cycle after entering ACTIVE; later loads wait for the
  // shift edge after a completed word so the last bit keeps its full
  // half-period on so. For CPHA=1 that shift edge is the first lead edge of
  // the next word, which is why a reload replaces the shift there.
  always_comb begin
    state_d     = state_q;
    enter       = 1'b0;
    do_clear    = 1'b0;
    do_load     = 1'b0;
    do_shift    = 1'b0;
    do_skip     = 1'b0;
    do_sample   = 1'b0;
    tx_ready    = 1'b0;
    tx_underrun = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          enter   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d  = IDLE;
          do_clear = 1'b1;
        end else begin
          if (load_pend_q) begin
            do_load = 1'b1;
          end else if (shift_edge) begin
            if (reload_pend_q) begin
              do_load = 1'b1;
            end else if (skip_shift_q) begin
              do_skip = 1'b1;
            end else begin
              do_shift = 1'b1;
            end
          end
          do_sample = sample_edge;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_ready    = do_load &  tx_valid;
    tx_underrun = do_load & ~tx_valid;
  end

  assign rx_next = MSB_FIRST ? {shift_rx_q[WIDTH-2:0], si_s}
                             : {si_s, shift_rx_q[WIDTH-1:1]};

  // rx_valid trails the rx_data update by one cycle via word_done_q.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shift_tx_q    <= '0;
      shift_rx_q    <= '0;
      bitcnt_q      <= '0;
      load_pend_q   <= 1'b0;
      reload_pend_q <= 1'b0;
      skip_shift_q  <= 1'b0;
      word_done_q   <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
    end else begin
      rx_valid_q  <= word_done_q;
      word_done_q <= 1'b0;
      if (enter) begin
        load_pend_q <= 1'b1;
      end
      if (do_clear) begin
        shift_tx_q    <= '0;
        shift_rx_q    <= '0;
        bitcnt_q      <= '0;
        load_pend_q   <= 1'b0;
        reload_pend_q <= 1'b0;
        skip_shift_q  <= 1'b0;
      end else begin
        if (do_load) begin
          shift_tx_q    <= tx_valid ? tx_data : FILL;
          bitcnt_q      <= '0;
          load_pend_q   <= 1'b0;
          reload_pend_q <= 1'b0;
          skip_shift_q  <= load_pend_q & CPHA;
        end
        if (do_skip) begin
          skip_shift_q <= 1'b0;
        end
        if (do_shift) begin
          shift_tx_q <= MSB_FIRST ? {shift_tx_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, shift_tx_q[WIDTH-1:1]};
        end
        if (do_sample) begin
          shift_rx_q <= rx_next;
          if (bitcnt_q == LAST_BIT) begin
            rx_data_q     <= rx_next;
            word_done_q   <= 1'b1;
            reload_pend_q <= 1'b1;
            bitcnt_q      <= '0;
          end else begin
            bitcnt_q <= bitcnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign so           = MSB_FIRST ? shift_tx_q[WIDTH-1] : shift_tx_q[0];
  assign frame_active = (state_q == ACTIVE);
  assign so_oe        = frame_active;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync
// Directed bench: a 16-bit mode-0 MSB-first slave plus four 8-bit LSB-first
// slaves (one per CPOL/CPHA mode) share sck and si; each has its own cs.
module tb_spi_slave_sync;

  localparam int HALF = 8;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        sck     = 1'b0;
  logic        si      = 1'b0;
  logic        cs16    = 1'b1;
  logic [3:0]  cs8     = 4'hF;

  logic        so16, so_oe16, rx_valid16, tx_ready16, tx_underrun16, frame_active16;
  logic [15:0] rx_data16;
  logic [15:0] tx_data16;
  logic        tx_valid16 = 1'b1;
  logic [15:0] tx_tab [4];
  int          tx_base = 0;

  logic [3:0]  so8, so_oe8, rx_valid8, tx_ready8, tx_underrun8, frame_active8;
  logic [7:0]  rx_data8 [4];
  logic [7:0]  tx_data8  = 8'h3C;
  logic        tx_valid8 = 1'b1;

  int rx_cnt16 = 0, ready_cnt16 = 0, under_cnt16 = 0, ready_at_rx16 = 0;
  int rx_cnt8 [4] = '{0, 0, 0, 0};
  int ready_cnt8 [4] = '{0, 0, 0, 0};
  int under_cnt8 [4] = '{0, 0, 0, 0};

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign tx_data16 = tx_tab[2'(ready_cnt16 - tx_base)];

  spi_slave_sync #(
    .WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .FILL(16'hFFFF)
  ) u_dut16 (
    .clock(clock), .reset_n(reset_n), .sck(sck), .cs(cs16), .si(si),
    .so(so16), .so_oe(so_oe16), .rx_data(rx_data16), .rx_valid(rx_valid16),
    .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
    .tx_underrun(tx_underrun16), .frame_active(frame_active16)
  );

  for (genvar m = 0; m < 4; m++) begin : g_mode
    spi_slave_sync #(
      .WIDTH(8), .CPOL(m >= 2), .CPHA((m % 2) == 1), .MSB_FIRST(1'b0), .FILL(8'hFF)
    ) u_dut8 (
      .clock(clock), .reset_n(reset_n), .sck(sck), .cs(cs8[m]), .si(si),
      .so(so8[m]), .so_oe(so_oe8[m]), .rx_data(rx_data8[m]), .rx_valid(rx_valid8[m]),
      .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8[m]),
      .tx_underrun(tx_underrun8[m]), .frame_active(frame_active8[m])
    );
  end

  // Strobe counters; ready_at_rx16 records how many tx words had been taken
  // when each 16-bit word completed.
  always @(posedge clock) begin
    if (rx_valid16) begin
      rx_cnt16      <= rx_cnt16 + 1;
      ready_at_rx16 <= ready_cnt16;
    end
    if (tx_ready16)    ready_cnt16 <= ready_cnt16 + 1;
    if (tx_underrun16) under_cnt16 <= under_cnt16 + 1;
    for (int m = 0; m < 4; m++) begin
      if (rx_valid8[m])    rx_cnt8[m]    <= rx_cnt8[m] + 1;
      if (tx_ready8[m])    ready_cnt8[m] <= ready_cnt8[m] + 1;
      if (tx_underrun8[m]) under_cnt8[m] <= under_cnt8[m] + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic so_mux(input int sel);
    if (sel == 0) return so16;
    return so8[2'(sel - 1)];
  endfunction

  task automatic set_cs(input int sel, input logic val);
    if (sel == 0) cs16 = val;
    else cs8[2'(sel - 1)] = val;
  endtask

  task automatic frame_begin(input int sel, input logic cpol);
    sck = cpol;
    wait_clk(4);
    set_cs(sel, 1'b0);
    wait_clk(6);
  endtask

  task automatic frame_end(input int sel);
    set_cs(sel, 1'b1);
    wait_clk(6);
  endtask

  // Master side of one word (or its first nbits bits); returns what was seen on so.
  task automatic apply_stimulus(input int sel, input logic cpol, input logic cpha,
                                input int width, input logic msb, input int nbits,
                                input logic [31:0] mosi, output logic [31:0] miso);
    int b;
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      b = msb ? (width - 1 - i) : i;
      if (!cpha) begin
        si = mosi[b];
        wait_clk(HALF);
        miso[b] = so_mux(sel);
        sck = ~cpol;
        wait_clk(HALF);
        sck = cpol;
      end else begin
        sck = ~cpol;
        si = mosi[b];
        wait_clk(HALF);
        miso[b] = so_mux(sel);
        sck = cpol;
        wait_clk(HALF);
      end
    end
    wait_clk(HALF);
  endtask

  initial begin
    logic [31:0] miso;
    logic [15:0] rx_words [3];
    logic [15:0] tx_words [3];
    int rx0, un0, rd0;

    for (int i = 0; i < 4; i++) tx_tab[i] = 16'h1234;
    wait_clk(5);
    reset_n = 1'b1;
    wait_clk(4);

    $display("[TB] reset values");
    check_output("rst_so",           32'(so16),           32'h0);
    check_output("rst_so_oe",        32'(so_oe16),        32'h0);
    check_output("rst_rx_data",      32'(rx_data16),      32'h0);
    check_output("rst_rx_valid",     32'(rx_valid16),     32'h0);
    check_output("rst_tx_ready",     32'(tx_ready16),     32'h0);
    check_output("rst_tx_underrun",  32'(tx_underrun16),  32'h0);
    check_output("rst_frame_active", 32'(frame_active16), 32'h0);

    $display("[TB] mode 0, 16-bit MSB first");
    tx_base = ready_cnt16;
    rx0 = rx_cnt16;
    frame_begin(0, 1'b0);
    check_output("m0_frame_active", 32'({frame_active16, so_oe16}), 32'h3);
    apply_stimulus(0, 1'b0, 1'b0, 16, 1'b1, 16, 32'hA5C3, miso);
    frame_end(0);
    check_output("m0_rx_data",  32'(rx_data16),  32'hA5C3);
    check_output("m0_rx_count", rx_cnt16 - rx0,  32'd1);
    check_output("m0_miso",     miso,            32'h1234);

    $display("[TB] all modes, 8-bit LSB first");
    for (int m = 0; m < 4; m++) begin
      logic cpol, cpha;
      cpol = (m >= 2);
      cpha = ((m % 2) == 1);
      rx0 = rx_cnt8[m];
      un0 = under_cnt8[m];
      rd0 = ready_cnt8[m];
      frame_begin(m + 1, cpol);
      check_output($sformatf("mode%0d_active", m), 32'({frame_active8[m], so_oe8[m]}), 32'h3);
      apply_stimulus(m + 1, cpol, cpha, 8, 1'b0, 8, 32'h81, miso);
      frame_end(m + 1);
      check_output($sformatf("mode%0d_rx_data", m),  32'(rx_data8[m]),    32'h81);
      check_output($sformatf("mode%0d_miso", m),     miso,                32'h3C);
      check_output($sformatf("mode%0d_rx_count", m), rx_cnt8[m] - rx0,    32'd1);
      check_output($sformatf("mode%0d_underrun", m), under_cnt8[m] - un0, 32'd0);
      check_output($sformatf("mode%0d_tx_ready", m), ready_cnt8[m] - rd0, cpha ? 32'd1 : 32'd2);
    end
    sck = 1'b0;
    wait_clk(4);

    $display("[TB] three back-to-back words");
    rx_words = '{16'hCAFE, 16'h0123, 16'h8001};
    tx_words = '{16'h5A5A, 16'hF00F, 16'h9669};
    for (int i = 0; i < 3; i++) tx_tab[i] = tx_words[i];
    tx_tab[3] = 16'h0000;
    tx_base = ready_cnt16;
    rx0 = rx_cnt16;
    frame_begin(0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1'b0, 1'b0, 16, 1'b1, 16, 32'(rx_words[i]), miso);
      check_output($sformatf("b2b_rx_word%0d", i), 32'(rx_data16), 32'(rx_words[i]));
      check_output($sformatf("b2b_miso%0d", i),    miso,           32'(tx_words[i]));
    end
    check_output("b2b_rx_count",       rx_cnt16 - rx0,          32'd3);
    check_output("b2b_tx_ready_count", ready_at_rx16 - tx_base, 32'd3);
    frame_end(0);

    $display("[TB] underrun");
    for (int i = 0; i < 4; i++) tx_tab[i] = 16'h1234;
    tx_base = ready_cnt16;
    tx_valid16 = 1'b0;
    un0 = under_cnt16;
    rd0 = ready_cnt16;
    frame_begin(0, 1'b0);
    check_output("ur_underrun", under_cnt16 - un0, 32'd1);
    check_output("ur_tx_ready", ready_cnt16 - rd0, 32'd0);
    apply_stimulus(0, 1'b0, 1'b0, 16, 1'b1, 16, 32'h0F0F, miso);
    frame_end(0);
    check_output("ur_miso", miso, 32'hFFFF);
    tx_valid16 = 1'b1;

    $display("[TB] partial word then full word");
    tx_base = ready_cnt16;
    rx0 = rx_cnt16;
    frame_begin(0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 16, 1'b1, 5, 32'hF800, miso);
    frame_end(0);
    check_output("part_rx_count",    rx_cnt16 - rx0,                 32'd0);
    check_output("part_idle_outs",   32'({frame_active16, so_oe16, so16}), 32'h0);
    frame_begin(0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 16, 1'b1, 16, 32'h00FF, miso);
    frame_end(0);
    check_output("part_next_rx",     32'(rx_data16), 32'h00FF);
    check_output("part_next_count",  rx_cnt16 - rx0, 32'd1);
    check_output("part_next_miso",   miso,           32'h1234);

    $display("[TB] reset mid-word");
    tx_base = ready_cnt16;
    frame_begin(0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 16, 1'b1, 7, 32'hBEEF, miso);
    reset_n = 1'b0;
    wait_clk(3);
    check_output("mr_so",           32'(so16),           32'h0);
    check_output("mr_so_oe",        32'(so_oe16),        32'h0);
    check_output("mr_rx_data",      32'(rx_data16),      32'h0);
    check_output("mr_rx_valid",     32'(rx_valid16),     32'h0);
    check_output("mr_tx_strobes",   32'({tx_ready16, tx_underrun16}), 32'h0);
    check_output("mr_frame_active", 32'(frame_active16), 32'h0);
    reset_n = 1'b1;
    wait_clk(4);
    rx0 = rx_cnt16;
    apply_stimulus(0, 1'b0, 1'b0, 16, 1'b1, 9, 32'hBEEF, miso);
    check_output("mr_ignored_active", 32'(frame_active16), 32'h0);
    check_output("mr_ignored_count",  rx_cnt16 - rx0,      32'd0);
    frame_end(0);
    tx_base = ready_cnt16;
    frame_begin(0, 1'b0);
    apply_stimulus(0, 1'b0, 1'b0, 16, 1'b1, 16, 32'hBEEF, miso);
    frame_end(0);
    check_output("mr_next_rx",    32'(rx_data16), 32'hBEEF);
    check_output("mr_next_count", rx_cnt16 - rx0, 32'd1);
    check_output("mr_next_miso",  miso,           32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
